// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 responder.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } spi_slv_state_e;

  localparam int   SPI_BITCNT_W = 8;
  localparam logic CPOL         = 1'b0;
  localparam logic CPHA         = 1'b0;

  // Bit counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [SPI_BITCNT_W-1:0] sat_inc(input logic [SPI_BITCNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, with rise/fall pulses
// derived from the last stage against a one-cycle delayed copy.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   last_q, last_d;

  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    last_d = sync_q[SYNC_STAGES-1];
  end

  // Reset to 0 everywhere: a pin already low after reset produces no edge,
  // so a frame interrupted by reset is never picked up half-way.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & last_q;

endmodule

// File: rtl/spi_slv.sv
// SPI mode-0 responder: oversampled pins, RX capture of the last RX_LEN bytes,
// preloaded TX_LEN-byte response shifted out MSB first.
module spi_slv
  import spi_pkg::*;
#(
  parameter int TX_LEN      = 2,
  parameter int RX_LEN      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TX_LEN*8-1:0] tx_data,
  input  logic                tx_load,
  output logic [RX_LEN*8-1:0] rx_data,
  output logic [7:0]          rx_bits,
  output logic                rx_vld,
  input  logic                rx_ack,
  output logic                overrun,
  output logic                busy,
  input  logic                SPI_SCLK,
  input  logic                SPI_CS,
  input  logic                SPI_MOSI,
  output logic                SPI_MISO,
  output logic                SPI_MISO_OE
);

  localparam int TX_W = TX_LEN * 8;
  localparam int RX_W = RX_LEN * 8;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic sclk_s_unused, cs_s_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk (clk), .rst (rst), .din (SPI_SCLK),
    .dout(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk (clk), .rst (rst), .din (SPI_CS),
    .dout(cs_s_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk (clk), .rst (rst), .din (SPI_MOSI),
    .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_slv_state_e          state_q, state_d;
  logic [TX_W-1:0]         shadow_q, shadow_d;
  logic [TX_W-1:0]         tx_sr_q, tx_sr_d;
  logic [RX_W-1:0]         rx_sr_q, rx_sr_d;
  logic [SPI_BITCNT_W-1:0] cnt_q, cnt_d;
  logic                    miso_q, miso_d;
  logic                    busy_q, busy_d;
  logic [RX_W-1:0]         rx_data_q, rx_data_d;
  logic [7:0]              rx_bits_q, rx_bits_d;
  logic                    rx_vld_q, rx_vld_d;
  logic                    overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    shadow_d  = tx_load ? tx_data : shadow_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    cnt_d     = cnt_q;
    miso_d    = miso_q;
    busy_d    = busy_q;
    rx_data_d = rx_data_q;
    rx_bits_d = rx_bits_q;
    rx_vld_d  = rx_vld_q & ~rx_ack;
    overrun_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          tx_sr_d = shadow_q;
          miso_d  = shadow_q[TX_W-1];
          cnt_d   = '0;
          rx_sr_d = '0;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        // CS release wins over any SCLK edge seen in the same cycle.
        if (cs_rise) begin
          state_d = COMMIT;
          busy_d  = 1'b0;
          miso_d  = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_sr_d = RX_W'({rx_sr_q, mosi_s});
            cnt_d   = sat_inc(cnt_q);
          end
          if (sclk_fall) begin
            tx_sr_d = tx_sr_q << 1;
            miso_d  = tx_sr_q[TX_W-2];
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        // A commit overrides a simultaneous ack, so vld stays set.
        if (cnt_q != '0) begin
          rx_data_d = rx_sr_q;
          rx_bits_d = cnt_q;
          rx_vld_d  = 1'b1;
          overrun_d = rx_vld_q & ~rx_ack;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      cnt_q     <= '0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
      rx_data_q <= '0;
      rx_bits_q <= '0;
      rx_vld_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      cnt_q     <= cnt_d;
      miso_q    <= miso_d;
      busy_q    <= busy_d;
      rx_data_q <= rx_data_d;
      rx_bits_q <= rx_bits_d;
      rx_vld_q  <= rx_vld_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_bits     = rx_bits_q;
  assign rx_vld      = rx_vld_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;
  assign SPI_MISO    = miso_q;
  assign SPI_MISO_OE = busy_q;

endmodule

// File: tb/tb_spi_slv.sv
// Directed bench for spi_slv: a table of full frames plus hand-written
// sequences for mid-frame load, mid-frame reset and an empty CS pulse.
module tb_spi_slv;

  localparam int SYNC = 2;
  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst, tx_load, rx_ack, sclk, cs, mosi;
  logic [15:0] tx_data;
  logic [15:0] rx_data;
  logic [7:0]  rx_bits;
  logic        rx_vld, overrun, busy, miso, miso_oe;

  int checks = 0;
  int failures = 0;
  int ovr_cycles = 0;
  int busy_cycles = 0;

  always #5 clk = ~clk;

  spi_slv #(.TX_LEN(2), .RX_LEN(2), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_load(tx_load),
    .rx_data(rx_data), .rx_bits(rx_bits), .rx_vld(rx_vld), .rx_ack(rx_ack),
    .overrun(overrun), .busy(busy), .SPI_SCLK(sclk), .SPI_CS(cs),
    .SPI_MOSI(mosi), .SPI_MISO(miso), .SPI_MISO_OE(miso_oe)
  );

  always @(posedge clk) begin
    if (overrun) ovr_cycles <= ovr_cycles + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
  end

  typedef struct {
    logic        load;
    logic [15:0] tx;
    logic [31:0] mosi_word;
    int          nbits;
    logic [15:0] exp_rx;
    logic [7:0]  exp_bits;
    logic [31:0] exp_miso;
    int          exp_ovr;
    logic        ack;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    step(HALF);
    sclk = 1'b1;
    m = miso;
    step(HALF);
    sclk = 1'b0;
  endtask

  task automatic frame(input logic [31:0] mo, input int n, input int load_at,
                       input logic [15:0] load_val, output logic [31:0] mi);
    logic m;
    mi = '0;
    cs = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      if (n - 1 - i == load_at) begin
        tx_data = load_val;
        tx_load = 1'b1;
        step(1);
        tx_load = 1'b0;
      end
      spi_bit(mo[i], m);
      mi = {mi[30:0], m};
    end
    step(HALF);
    cs = 1'b1;
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    step(1);
    rx_ack = 1'b0;
    chk("ack_clears_vld", {31'b0, rx_vld}, 32'd0);
  endtask

  initial begin
    logic [31:0] mi;
    logic        m;
    int          o0, b0;

    vecs[0] = '{1'b1, 16'h3C96, 32'h0000A55A, 16, 16'hA55A, 8'd16, 32'h00003C96, 0, 1'b0};
    vecs[1] = '{1'b0, 16'h0000, 32'h00001234, 16, 16'h1234, 8'd16, 32'h00003C96, 1, 1'b1};
    vecs[2] = '{1'b0, 16'h0000, 32'h00000016, 5,  16'h0016, 8'd5,  32'h00000007, 0, 1'b1};
    vecs[3] = '{1'b0, 16'h0000, 32'h00ABCDEF, 24, 16'hCDEF, 8'd24, 32'h003C9600, 0, 1'b1};

    rst = 1'b1; tx_load = 1'b0; rx_ack = 1'b0; tx_data = '0;
    sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);
    chk("reset rx_data", {16'b0, rx_data}, 32'd0);
    chk("reset rx_bits", {24'b0, rx_bits}, 32'd0);
    chk("reset rx_vld", {31'b0, rx_vld}, 32'd0);
    chk("reset overrun", {31'b0, overrun}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset miso", {31'b0, miso}, 32'd0);
    chk("reset miso_oe", {31'b0, miso_oe}, 32'd0);
    step(5);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].load) begin
        tx_data = vecs[v].tx;
        tx_load = 1'b1;
        step(1);
        tx_load = 1'b0;
      end
      o0 = ovr_cycles;
      frame(vecs[v].mosi_word, vecs[v].nbits, -1, 16'h0, mi);
      step(SYNC + 2);
      chk($sformatf("vec%0d rx_vld", v), {31'b0, rx_vld}, 32'd1);
      chk($sformatf("vec%0d rx_data", v), {16'b0, rx_data}, {16'b0, vecs[v].exp_rx});
      chk($sformatf("vec%0d rx_bits", v), {24'b0, rx_bits}, {24'b0, vecs[v].exp_bits});
      chk($sformatf("vec%0d miso", v), mi, vecs[v].exp_miso);
      step(1);
      chk($sformatf("vec%0d overrun", v), ovr_cycles - o0, vecs[v].exp_ovr);
      $display("vec%0d mosi=%h bits=%0d rx_data=%h rx_bits=%0d miso=%h", v,
               vecs[v].mosi_word, vecs[v].nbits, rx_data, rx_bits, mi);
      if (vecs[v].ack) do_ack();
      step(2);
    end

    // Mid-frame shadow update only affects the following frame.
    frame(32'h0F0F, 16, 4, 16'hFFFF, mi);
    step(SYNC + 2);
    chk("midload cur miso", mi, 32'h3C96);
    chk("midload rx_data", {16'b0, rx_data}, 32'h0F0F);
    $display("midload frame miso=%h rx_data=%h", mi, rx_data);
    do_ack();
    step(2);
    frame(32'h0000, 16, -1, 16'h0, mi);
    step(SYNC + 2);
    chk("midload next miso", mi, 32'hFFFF);
    chk("midload next rx_bits", {24'b0, rx_bits}, 32'd16);
    $display("next frame miso=%h rx_bits=%0d", mi, rx_bits);
    do_ack();
    step(2);

    // Reset in the middle of a frame: nothing commits.
    cs = 1'b0;
    for (int i = 0; i < 8; i++) spi_bit(i[0], m);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst miso_oe", {31'b0, miso_oe}, 32'd0);
    step(HALF);
    cs = 1'b1;
    step(8);
    chk("midrst rx_vld", {31'b0, rx_vld}, 32'd0);
    chk("midrst rx_bits", {24'b0, rx_bits}, 32'd0);
    $display("midframe reset rx_vld=%0d busy=%0d", rx_vld, busy);
    frame(32'hC3A5, 16, -1, 16'h0, mi);
    step(SYNC + 2);
    chk("postrst rx_vld", {31'b0, rx_vld}, 32'd1);
    chk("postrst rx_data", {16'b0, rx_data}, 32'hC3A5);
    chk("postrst miso", mi, 32'h0000);
    $display("post-reset frame rx_data=%h miso=%h", rx_data, mi);

    // Empty CS pulse with rx_vld left set: no commit, busy tracks CS.
    step(2);
    b0 = busy_cycles;
    o0 = ovr_cycles;
    cs = 1'b0;
    step(6);
    cs = 1'b1;
    step(SYNC + 4);
    chk("cspulse busy cycles", busy_cycles - b0, 32'd6);
    chk("cspulse rx_vld", {31'b0, rx_vld}, 32'd1);
    chk("cspulse rx_bits", {24'b0, rx_bits}, 32'd16);
    chk("cspulse rx_data", {16'b0, rx_data}, 32'hC3A5);
    chk("cspulse overrun", ovr_cycles - o0, 32'd0);
    $display("cs pulse busy_cycles=%0d rx_vld=%0d", busy_cycles - b0, rx_vld);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
